// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: 128 KB RAM, host byte FIFOs, cycle counter.
// Ports: clk_in/rst_in; mem_a/mem_wr/mem_dout/mem_din/rdy_out to the CPU;
// in_valid/in_data/in_ready and out_valid/out_data/out_ready to the host;
// prog_stop is a sticky stop flag raised by the CPU.
module mem_bus_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        prog_stop
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // ------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------
  logic              w_io;
  logic [15:0]       w_io_off;
  logic              w_sel_in;
  logic              w_sel_cnt;
  logic              w_rd;
  logic              w_io_en;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_unused_hi;

  assign w_io       = (mem_a[17:16] == 2'b11);
  assign w_io_off   = mem_a[15:0];
  assign w_sel_in   = w_io && (w_io_off == 16'h0000);
  assign w_sel_cnt  = w_io && (w_io_off[15:2] == 14'h0001);
  assign w_rd       = !mem_wr;
  assign w_ram_addr = mem_a[RAM_AW-1:0];
  assign w_unused_hi = ^mem_a[31:18];

  // I/O side effects only happen while the CPU is not being paused.
  assign w_io_en = rdy_out;

  // ------------------------------------------------------------
  // Input FIFO (host -> CPU)
  // ------------------------------------------------------------
  logic [7:0]    r_in_mem [FIFO_DEPTH];
  logic [PW-1:0] r_in_wp;
  logic [PW-1:0] r_in_rp;
  logic [CW-1:0] r_in_cnt;
  logic          w_in_push;
  logic          w_in_pop;
  logic          w_in_nempty;
  logic [7:0]    w_in_head;

  assign in_ready    = (r_in_cnt < DEPTH_C);
  assign w_in_nempty = (r_in_cnt != '0);
  assign w_in_head   = r_in_mem[r_in_rp];
  assign w_in_push   = in_valid && in_ready;
  assign w_in_pop    = w_io_en && w_rd && w_sel_in && w_in_nempty;

  always_ff @(posedge clk_in) begin
    if (w_in_push) begin
      r_in_mem[r_in_wp] <= in_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_in_wp <= r_in_wp + 1'b1;
      end
      if (w_in_pop) begin
        r_in_rp <= r_in_rp + 1'b1;
      end
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
        2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------
  // Output FIFO (CPU -> host)
  // ------------------------------------------------------------
  logic [7:0]    r_out_mem [FIFO_DEPTH];
  logic [PW-1:0] r_out_wp;
  logic [PW-1:0] r_out_rp;
  logic [CW-1:0] r_out_cnt;
  logic          w_stop_wr;
  logic          w_chr_wr;
  logic          w_out_push;
  logic          w_out_pop;
  logic [7:0]    w_out_wdata;

  assign rdy_out   = (r_out_cnt < DEPTH_C);
  assign out_valid = (r_out_cnt != '0);
  assign out_data  = r_out_mem[r_out_rp];

  // A write to the counter base address stops the program and
  // sends a 0x00 marker so the host sees the stop in-band.
  assign w_stop_wr = w_io_en && mem_wr && w_sel_cnt &&
                     (w_io_off[1:0] == 2'b00);
  assign w_chr_wr  = w_io_en && mem_wr && w_sel_in &&
                     (mem_dout != 8'h00);
  assign w_out_push  = w_chr_wr || w_stop_wr;
  assign w_out_wdata = w_stop_wr ? 8'h00 : mem_dout;
  assign w_out_pop   = out_valid && out_ready;

  always_ff @(posedge clk_in) begin
    if (w_out_push) begin
      r_out_mem[r_out_wp] <= w_out_wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) begin
        r_out_wp <= r_out_wp + 1'b1;
      end
      if (w_out_pop) begin
        r_out_rp <= r_out_rp + 1'b1;
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------
  // Cycle counter, snapshot and stop flag
  // ------------------------------------------------------------
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  logic        r_stop;
  logic        w_snap;

  assign w_snap = w_io_en && w_rd && w_sel_cnt &&
                  (w_io_off[1:0] == 2'b00);
  assign prog_stop = r_stop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_stop <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_snap) begin
        r_snap <= r_cnt;
      end
      if (w_stop_wr) begin
        r_stop <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------
  // I/O read data
  // ------------------------------------------------------------
  logic [7:0] w_io_rdata;

  // The low counter byte comes from the live counter, which is the
  // same value being captured into the snapshot on this edge.
  always_comb begin
    w_io_rdata = 8'h00;
    if (w_io_en) begin
      unique case (1'b1)
        w_sel_in: begin
          w_io_rdata = w_in_nempty ? w_in_head : 8'h00;
        end
        w_sel_cnt: begin
          case (w_io_off[1:0])
            2'b00:   w_io_rdata = r_cnt[7:0];
            2'b01:   w_io_rdata = r_snap[15:8];
            2'b10:   w_io_rdata = r_snap[23:16];
            default: w_io_rdata = r_snap[31:24];
          endcase
        end
        default: begin
          w_io_rdata = 8'h00;
        end
      endcase
    end
  end

  // ------------------------------------------------------------
  // RAM with synchronous read port
  // ------------------------------------------------------------
  logic [7:0] r_ram [1 << RAM_AW];
  logic [7:0] r_ram_q;

  // Kept free of reset so it maps onto block RAM; contents survive
  // a reset by design.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !w_io) begin
      if (mem_wr) begin
        r_ram[w_ram_addr] <= mem_dout;
      end else begin
        r_ram_q <= r_ram[w_ram_addr];
      end
    end
  end

  // ------------------------------------------------------------
  // Response select
  // ------------------------------------------------------------
  logic       r_sel_ram;
  logic [7:0] r_io_q;

  // Write cycles leave both the select and the data untouched, so
  // mem_din keeps its previous value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel_ram <= 1'b0;
      r_io_q    <= 8'h00;
    end else if (w_rd) begin
      r_sel_ram <= !w_io;
      if (w_io) begin
        r_io_q <= w_io_rdata;
      end
    end
  end

  assign mem_din = r_sel_ram ? r_ram_q : r_io_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder.
// Read results are queued at issue time and compared one edge later.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h0003_0008;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        prog_stop;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  exp_q[$];
  string       tag_q[$];
  logic [31:0] m_cnt;

  mem_bus_responder dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .rdy_out   (rdy_out),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .prog_stop (prog_stop)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle count: value the DUT counter holds between edges.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) m_cnt <= 32'd0;
    else        m_cnt <= m_cnt + 32'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    string t;
    logic [7:0] e;
    @(posedge clk_in);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(mem_din), 32'(e));
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e,
                    input string t);
    mem_a  = a;
    mem_wr = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(t);
    step();
  endtask

  task automatic rd_nc(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    step();
    mem_wr   = 1'b0;
  endtask

  task automatic idle();
    rd(32'h0003_0008, 8'h00, "idle_io");
  endtask

  initial begin
    // Reset state, checked asynchronously before any clock edge
    #2 rst_in = 1'b1;
    #1;
    chk("rst_mem_din", 32'(mem_din), 32'h00);
    chk("rst_rdy_out", 32'(rdy_out), 32'h1);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_prog_stop", 32'(prog_stop), 32'h0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // RAM write then read
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010, 8'hA5, "ram_rd_a5");
    wr(32'h0000_0020, 8'h77);
    chk("wr_keeps_din", 32'(mem_din), 32'hA5);
    rd(32'h0000_0020, 8'h77, "ram_rd_77");
    wr(32'h0001_FFFF, 8'h3C);
    rd(32'h0001_FFFF, 8'h3C, "ram_top");
    rd(32'h0000_0010, 8'hA5, "ram_reread");

    // Input FIFO: two bytes then an empty read
    in_valid = 1'b1;
    in_data  = 8'h41;
    idle();
    in_data  = 8'h42;
    idle();
    in_valid = 1'b0;
    rd(32'h0003_0000, 8'h41, "in_pop_41");
    rd(32'h0003_0000, 8'h42, "in_pop_42");
    rd(32'h0003_0000, 8'h00, "in_pop_empty");
    chk("in_ready_after", 32'(in_ready), 32'h1);

    // Input FIFO fill, full, pop+push, wrap
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h50 + 8'(i);
      idle();
    end
    chk("in_full_ready", 32'(in_ready), 32'h0);
    in_data = 8'h58;
    rd(32'h0003_0000, 8'h50, "in_full_pop");
    chk("in_ready_reopen", 32'(in_ready), 32'h1);
    rd(32'h0003_0000, 8'h51, "in_push_pop");
    in_valid = 1'b0;
    for (int i = 2; i < 8; i++) begin
      rd(32'h0003_0000, 8'h50 + 8'(i), "in_drain");
    end
    rd(32'h0003_0000, 8'h58, "in_drain_last");
    rd(32'h0003_0000, 8'h00, "in_drain_empty");

    // Zero write to output port is ignored
    wr(32'h0003_0000, 8'h00);
    chk("zero_no_push", 32'(out_valid), 32'h0);

    // Output FIFO fill and stall
    for (int i = 0; i < 8; i++) begin
      wr(32'h0003_0000, 8'h31);
      if (i == 6) chk("rdy_at_7", 32'(rdy_out), 32'h1);
    end
    chk("rdy_at_8", 32'(rdy_out), 32'h0);
    wr(32'h0003_0000, 8'h32);
    chk("rdy_9th", 32'(rdy_out), 32'h0);

    // Stalled: no pop, no stop, no push
    in_valid = 1'b1;
    in_data  = 8'h61;
    rd_nc(32'h0003_0000);
    in_valid = 1'b0;
    wr(32'h0003_0004, 8'h01);
    chk("stall_no_stop", 32'(prog_stop), 32'h0);
    chk("stall_head", 32'(out_data), 32'h31);

    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("rdy_after_pop", 32'(rdy_out), 32'h1);
    rd(32'h0003_0000, 8'h61, "stall_no_pop");

    // Push and pop together at DEPTH-1
    out_ready = 1'b1;
    wr(32'h0003_0000, 8'h33);
    out_ready = 1'b0;
    chk("rdy_pushpop", 32'(rdy_out), 32'h1);
    for (int i = 0; i < 7; i++) begin
      chk("out_valid_drain", 32'(out_valid), 32'h1);
      chk("out_data_drain", 32'(out_data),
          (i < 6) ? 32'h31 : 32'h33);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
    end
    chk("out_empty", 32'(out_valid), 32'h0);

    // Program stop
    wr(32'h0003_0004, 8'h99);
    chk("stop_set", 32'(prog_stop), 32'h1);
    chk("stop_valid", 32'(out_valid), 32'h1);
    chk("stop_data", 32'(out_data), 32'h00);
    wr(32'h0003_0008, 8'h12);
    rd(32'h0003_000C, 8'h00, "other_io_rd");
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("other_io_no_push", 32'(out_valid), 32'h0);

    // Counter snapshot
    begin
      int g;
      g = 0;
      while (m_cnt != 32'h1FF && g < 2000) begin
        idle();
        g++;
      end
      chk("cnt_reach_timeout", m_cnt, 32'h1FF);
    end
    rd(32'h0003_0004, 8'hFF, "snap_b0");
    repeat (9) idle();
    rd(32'h0003_0005, 8'h01, "snap_b1");
    rd(32'h0003_0006, 8'h00, "snap_b2");
    rd(32'h0003_0007, 8'h00, "snap_b3");

    // Reset with both FIFOs loaded and stop set
    wr(32'h0000_0100, 8'h5A);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h71 + 8'(i);
      idle();
    end
    in_valid = 1'b0;
    wr(32'h0003_0000, 8'h01);
    wr(32'h0003_0000, 8'h02);
    wr(32'h0003_0004, 8'h55);
    chk("pre_rst_stop", 32'(prog_stop), 32'h1);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    rd(32'h0000_0100, 8'h5A, "pre_rst_ram");
    #2 rst_in = 1'b1;
    #1;
    chk("arst_mem_din", 32'(mem_din), 32'h00);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_prog_stop", 32'(prog_stop), 32'h0);
    chk("arst_rdy_out", 32'(rdy_out), 32'h1);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    mem_a  = 32'h0003_0004;
    mem_wr = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_q.push_back(8'h00);
    tag_q.push_back("cnt_after_rst");
    step();
    rd(32'h0003_0000, 8'h00, "in_empty_after_rst");
    rd(32'h0000_0100, 8'h5A, "ram_kept");
    rd(32'h0003_0004, 8'h03, "cnt_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
